core_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: fetches, holds the current instruction, and steps it through EXECUTE/MEM/WRITEBACK.

---
 rtl/core_ctrl_pkg.sv | 38 +++
 rtl/core_ctrl_if.sv | 26 ++
 rtl/core_ctrl_inst_class.sv | 26 ++
 rtl/core_ctrl.sv | 96 +++++++++
 tb/tb_core_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: ISA opcodes, sequencer states and
// the instruction-class bundle passed from the classifier to the controller.
package core_ctrl_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] ISA_OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] ISA_OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] ISA_OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] ISA_OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] ISA_OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] ISA_OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] ISA_OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] ISA_OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] ISA_OPCODE_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam word_t ISA_NOP              = 32'h0000_0013;
  localparam word_t DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    EXECUTE    = 3'd2,
    MEM        = 3'd3,
    MEM_WAIT   = 3'd4,
    WRITEBACK  = 3'd5,
    TRAP       = 3'd6
  } ctrl_state_t;

  typedef struct packed {
    logic is_mem;
    logic is_store;
    logic writes_rd;
    logic legal;
  } inst_class_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction and data bus bundle between the sequencer (master) and memory (slave).
interface core_ctrl_if;
  import core_ctrl_pkg::*;

  // A request transfers on a cycle where valid & ready are both high; the master keeps
  // valid high until that cycle. rvalid is a single-cycle response strobe with no ready.
  logic  ibus_valid;
  logic  ibus_ready;
  logic  ibus_rvalid;
  word_t ibus_rdata;
  logic  dbus_valid;
  logic  dbus_we;
  logic  dbus_ready;
  logic  dbus_rvalid;

  modport master (
    output ibus_valid, dbus_valid, dbus_we,
    input  ibus_ready, ibus_rvalid, ibus_rdata, dbus_ready, dbus_rvalid
  );

  modport slave (
    input  ibus_valid, dbus_valid, dbus_we,
    output ibus_ready, ibus_rvalid, ibus_rdata, dbus_ready, dbus_rvalid
  );

endinterface

// File: rtl/core_ctrl_inst_class.sv
// Combinational opcode classifier: which path the sequencer takes and whether rd is written.
module core_ctrl_inst_class
  import core_ctrl_pkg::*;
(
  input  logic [6:0]  i_opcode,
  output inst_class_t o_cls
);

  // Field order: is_mem, is_store, writes_rd, legal
  always_comb begin
    o_cls = '0;
    case (i_opcode)
      ISA_OPCODE_LOAD:   o_cls = 4'b1011;
      ISA_OPCODE_STORE:  o_cls = 4'b1101;
      ISA_OPCODE_OP,
      ISA_OPCODE_OP_IMM,
      ISA_OPCODE_LUI,
      ISA_OPCODE_AUIPC,
      ISA_OPCODE_JAL,
      ISA_OPCODE_JALR:   o_cls = 4'b0011;
      ISA_OPCODE_BRANCH: o_cls = 4'b0001;
      default:           o_cls = 4'b0000;
    endcase
  end

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32I sequencer: owns pc, the instruction register, bus handshakes,
// register-file write strobe, retired-instruction count and the sticky trap.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter word_t       RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [63:0] INSTRET_INIT = 64'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  core_ctrl_if.master        bus,
  input  word_t              next_pc,
  output word_t              pc,
  output word_t              inst,
  output logic               rf_we,
  output logic [63:0]        instret,
  output logic               trap,
  output ctrl_state_t        dbg_state
);

  ctrl_state_t r_state;
  word_t       r_pc;
  word_t       r_inst;
  logic [63:0] r_instret;
  logic        r_is_store;
  logic        r_writes_rd;
  inst_class_t w_cls;
  logic        w_pc_misaligned;

  core_ctrl_inst_class u_inst_class (
    .i_opcode (r_inst[6:0]),
    .o_cls    (w_cls)
  );

  assign w_pc_misaligned = (next_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pc        <= RESET_VECTOR;
      r_inst      <= ISA_NOP;
      r_instret   <= INSTRET_INIT;
      r_is_store  <= 1'b0;
      r_writes_rd <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (bus.ibus_ready) r_state <= FETCH_WAIT;
        end
        // A response coincident with acceptance is never seen here: it lands in FETCH.
        FETCH_WAIT: begin
          if (bus.ibus_rvalid) begin
            r_inst  <= bus.ibus_rdata;
            r_state <= EXECUTE;
          end
        end
        EXECUTE: begin
          r_is_store  <= w_cls.is_store;
          r_writes_rd <= w_cls.writes_rd;
          if (!w_cls.legal)     r_state <= TRAP;
          else if (w_cls.is_mem) r_state <= MEM;
          else                   r_state <= WRITEBACK;
        end
        MEM: begin
          if (bus.dbus_ready) r_state <= r_is_store ? WRITEBACK : MEM_WAIT;
        end
        MEM_WAIT: begin
          if (bus.dbus_rvalid) r_state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (w_pc_misaligned) begin
            r_state <= TRAP;
          end else begin
            r_pc      <= next_pc;
            r_instret <= r_instret + 64'd1;
            r_state   <= FETCH;
          end
        end
        TRAP:    r_state <= TRAP;
        default: r_state <= TRAP;
      endcase
    end
  end

  // Strobes decode from the state register plus values latched in EXECUTE.
  assign bus.ibus_valid = (r_state == FETCH);
  assign bus.dbus_valid = (r_state == MEM);
  assign bus.dbus_we    = (r_state == MEM) && r_is_store;
  assign rf_we          = (r_state == WRITEBACK) && r_writes_rd && !w_pc_misaligned;
  assign trap           = (r_state == TRAP);
  assign pc             = r_pc;
  assign inst           = r_inst;
  assign instret        = r_instret;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: fetch/execute/writeback timing, load/store handshakes,
// illegal opcode and misaligned-pc traps, asynchronous reset and instret wrap.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  core_ctrl_if bus ();
  core_ctrl_if wbus ();

  word_t       next_pc;
  word_t       pc, inst;
  logic        rf_we, trap;
  logic [63:0] instret;
  ctrl_state_t dbg_state;

  word_t       w_pc, w_inst;
  logic        w_rf_we, w_trap;
  logic [63:0] w_instret;
  ctrl_state_t w_dbg_state;

  core_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .next_pc(next_pc),
    .pc(pc), .inst(inst), .rf_we(rf_we), .instret(instret),
    .trap(trap), .dbg_state(dbg_state)
  );

  // Free-running zero-wait instance preloaded near the instret wrap point.
  core_ctrl #(.INSTRET_INIT(64'hFFFF_FFFF_FFFF_FFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(wbus), .next_pc(32'h0000_0004),
    .pc(w_pc), .inst(w_inst), .rf_we(w_rf_we), .instret(w_instret),
    .trap(w_trap), .dbg_state(w_dbg_state)
  );

  assign wbus.ibus_ready  = 1'b1;
  assign wbus.ibus_rvalid = 1'b1;
  assign wbus.ibus_rdata  = 32'h0050_0093;
  assign wbus.dbus_ready  = 1'b0;
  assign wbus.dbus_rvalid = 1'b0;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  // Entered at a FETCH negedge; returns at the EXECUTE negedge with bus inputs idle.
  task automatic fetch(input word_t word);
    bus.ibus_ready = 1'b1;
    step();
    bus.ibus_ready  = 1'b0;
    bus.ibus_rvalid = 1'b1;
    bus.ibus_rdata  = word;
    step();
    bus.ibus_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int n_ival;
  int n_rfwe;

  initial begin
    bus.ibus_ready  = 1'b0;
    bus.ibus_rvalid = 1'b0;
    bus.ibus_rdata  = '0;
    bus.dbus_ready  = 1'b0;
    bus.dbus_rvalid = 1'b0;
    next_pc         = 32'h0000_0004;
    step();
    #1;
    chk("reset_pc", pc, 64'h0);
    chk("reset_inst", inst, 64'h13);
    chk("reset_instret", instret, 64'h0);
    chk("reset_trap", trap, 64'h0);
    chk("reset_rf_we", rf_we, 64'h0);
    chk("reset_dbus_valid", bus.dbus_valid, 64'h0);
    step();
    rst_n = 1'b1;

    // 1: addi x1,x0,5, zero-wait, cycle-by-cycle
    chk("t1_c0_ibus_valid", bus.ibus_valid, 64'h1);
    chk("t1_c0_rf_we", rf_we, 64'h0);
    bus.ibus_ready = 1'b1;
    step();
    chk("t1_c1_ibus_valid", bus.ibus_valid, 64'h0);
    chk("t1_c1_rf_we", rf_we, 64'h0);
    bus.ibus_ready  = 1'b0;
    bus.ibus_rvalid = 1'b1;
    bus.ibus_rdata  = 32'h0050_0093;
    step();
    bus.ibus_rvalid = 1'b0;
    chk("t1_c2_inst", inst, 64'h0050_0093);
    chk("t1_c2_rf_we", rf_we, 64'h0);
    step();
    chk("t1_c3_rf_we", rf_we, 64'h1);
    step();
    chk("t1_c4_rf_we", rf_we, 64'h0);
    chk("t1_pc", pc, 64'h4);
    chk("t1_instret", instret, 64'h1);
    chk("t1_c4_ibus_valid", bus.ibus_valid, 64'h1);

    // 2: lw x2,0(x0) with 3 stall cycles on dbus_ready, rvalid 2 cycles after accept
    fetch(32'h0000_2103);
    next_pc = 32'h0000_0008;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_dbus_valid", bus.dbus_valid, 64'h1);
      chk("t2_dbus_we", bus.dbus_we, 64'h0);
      chk("t2_mem_rf_we", rf_we, 64'h0);
      bus.dbus_ready = (i == 3);
      step();
    end
    bus.dbus_ready = 1'b0;
    chk("t2_wait_state", dbg_state, 64'(MEM_WAIT));
    chk("t2_wait_dbus_valid", bus.dbus_valid, 64'h0);
    chk("t2_wait_rf_we", rf_we, 64'h0);
    step();
    chk("t2_wait2_rf_we", rf_we, 64'h0);
    bus.dbus_rvalid = 1'b1;
    step();
    bus.dbus_rvalid = 1'b0;
    chk("t2_wb_rf_we", rf_we, 64'h1);
    step();
    chk("t2_after_rf_we", rf_we, 64'h0);
    chk("t2_pc", pc, 64'h8);
    chk("t2_instret", instret, 64'h2);

    // 3: sw x1,0(x2): no MEM_WAIT, no rf_we
    fetch(32'h0011_2023);
    next_pc = 32'h0000_000C;
    step();
    chk("t3_dbus_valid", bus.dbus_valid, 64'h1);
    chk("t3_dbus_we", bus.dbus_we, 64'h1);
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    chk("t3_wb_state", dbg_state, 64'(WRITEBACK));
    chk("t3_wb_rf_we", rf_we, 64'h0);
    chk("t3_wb_dbus_valid", bus.dbus_valid, 64'h0);
    step();
    chk("t3_pc", pc, 64'hC);
    chk("t3_instret", instret, 64'h3);

    // 4: illegal opcode -> sticky trap, bus silent
    fetch(32'h0000_007F);
    chk("t4_exec_trap", trap, 64'h0);
    step();
    chk("t4_trap", trap, 64'h1);
    n_ival = 0;
    n_rfwe = 0;
    bus.ibus_ready  = 1'b1;
    bus.dbus_ready  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.ibus_rvalid = i[0];
      bus.dbus_rvalid = ~i[0];
      step();
      if (bus.ibus_valid) n_ival++;
      if (rf_we) n_rfwe++;
    end
    bus.ibus_ready  = 1'b0;
    bus.dbus_ready  = 1'b0;
    bus.ibus_rvalid = 1'b0;
    bus.dbus_rvalid = 1'b0;
    chk("t4_ibus_valid_count", 64'(n_ival), 64'h0);
    chk("t4_rf_we_count", 64'(n_rfwe), 64'h0);
    chk("t4_trap_held", trap, 64'h1);
    chk("t4_pc_frozen", pc, 64'hC);
    chk("t4_inst_frozen", inst, 64'h7F);
    do_reset();
    chk("t4_reset_pc", pc, 64'h0);
    chk("t4_reset_trap", trap, 64'h0);
    chk("t4_reset_state", dbg_state, 64'(FETCH));

    // 5: jal x1,8 with misaligned successor -> trap, no write
    fetch(32'h0080_00EF);
    next_pc = 32'h0000_0102;
    step();
    chk("t5_wb_rf_we", rf_we, 64'h0);
    step();
    chk("t5_trap", trap, 64'h1);
    chk("t5_rf_we", rf_we, 64'h0);
    chk("t5_pc", pc, 64'h0);
    chk("t5_instret", instret, 64'h0);
    do_reset();

    // 6: retire one, then reset asynchronously inside MEM_WAIT
    next_pc = 32'h0000_0004;
    fetch(32'h0050_0093);
    step();
    step();
    chk("t6_pc_pre", pc, 64'h4);
    fetch(32'h0000_2103);
    step();
    bus.dbus_ready = 1'b1;
    step();
    bus.dbus_ready = 1'b0;
    chk("t6_in_mem_wait", dbg_state, 64'(MEM_WAIT));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_state", dbg_state, 64'(FETCH));
    chk("t6_async_pc", pc, 64'h0);
    chk("t6_async_inst", inst, 64'h13);
    chk("t6_async_instret", instret, 64'h0);
    chk("t6_async_ibus_valid", bus.ibus_valid, 64'h1);
    bus.dbus_rvalid = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    bus.dbus_rvalid = 1'b0;
    chk("t6_spurious_state", dbg_state, 64'(FETCH));
    chk("t6_spurious_rf_we", rf_we, 64'h0);
    chk("t6_spurious_instret", instret, 64'h0);

    // instret wrap on the preloaded zero-wait instance
    do_reset();
    chk("wrap_c0_instret", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    step();
    step();
    chk("wrap_c3_rf_we", w_rf_we, 64'h1);
    chk("wrap_c3_instret", w_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("wrap_instret", w_instret, 64'h0);
    chk("wrap_pc", w_pc, 64'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
